// File: rtl/pwm_pkg.sv
// Shared constants for the PID output stage: data widths and the PWM state encoding.
package pwm_pkg;

  localparam int MV_NB  = 32;
  localparam int INV_NB = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    RUN   = 3'b010,
    FAULT = 3'b100
  } pwm_state_t;

endpackage

// File: rtl/pwm_sat.sv
// Abs-and-clamp of the signed manipulation value against the PWM period.
// Latency: combinational. Backpressure: none.
module pwm_sat
  import pwm_pkg::*;
#(
  parameter int cnt_nb = 16
) (
  input  logic [MV_NB-1:0]  i_mv,
  input  logic [cnt_nb-1:0] i_period,
  output logic [cnt_nb-1:0] o_duty,
  output logic              o_sat
);

  logic [MV_NB:0] mv_ext;
  logic [MV_NB:0] mag;
  logic [MV_NB:0] period_ext;

  // One extra bit so that the magnitude of the most negative value still fits.
  always_comb begin
    mv_ext     = {i_mv[MV_NB-1], i_mv};
    mag        = i_mv[MV_NB-1] ? ((MV_NB+1)'(0) - mv_ext) : mv_ext;
    period_ext = {{(MV_NB+1-cnt_nb){1'b0}}, i_period};
    if (mag > period_ext) begin
      o_duty = i_period;
      o_sat  = 1'b1;
    end else begin
      o_duty = mag[cnt_nb-1:0];
      o_sat  = 1'b0;
    end
  end

endmodule

// File: rtl/pwm_actuator.sv
// Sign/magnitude PWM drive from the PID manipulation value; duty/period double-buffered per period.
// Latency: input sampled on the boundary clock, applied from cnt=0 next clock (worst case period_r clocks).
// Backpressure: none; PWM_FAULT_LATCH_EN makes an invalid sample latch into FAULT until i_en drops.
module pwm_actuator
  import pwm_pkg::*;
#(
  parameter int cnt_nb = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [MV_NB-1:0]  i_mv,
  input  logic [INV_NB-1:0] i_invalid,
  input  logic [cnt_nb-1:0] i_period,
  output logic              o_pwm,
  output logic              o_dir,
  output logic              o_sat,
  output logic              o_fault,
  output logic [cnt_nb-1:0] o_duty
);

  pwm_state_t        state;
  logic [cnt_nb-1:0] cnt;
  logic [cnt_nb-1:0] period_r;
  logic [cnt_nb-1:0] duty_r;
  logic              dir_r;
  logic              sat_r;
  logic              fault_r;

  logic [cnt_nb-1:0] duty_c;
  logic              sat_c;
  logic              dir_c;
  logic              inv_c;
  logic              boundary;

  pwm_sat #(
    .cnt_nb  (cnt_nb)
  ) u_sat (
    .i_mv     (i_mv),
    .i_period (i_period),
    .o_duty   (duty_c),
    .o_sat    (sat_c)
  );

  assign dir_c    = i_mv[MV_NB-1];
  assign inv_c    = |i_invalid;
  assign boundary = (cnt == (period_r - cnt_nb'(1)));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_r <= '0;
      duty_r   <= '0;
      dir_r    <= 1'b0;
      sat_r    <= 1'b0;
      fault_r  <= 1'b0;
    end else if (!i_en) begin
      state    <= IDLE;
      cnt      <= '0;
      duty_r   <= '0;
      dir_r    <= 1'b0;
      sat_r    <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_period != '0) begin
            state    <= RUN;
            cnt      <= '0;
            period_r <= i_period;
            dir_r    <= dir_c;
            if (inv_c) begin
              // Starting on a bad sample: run with zero duty rather than trust the value.
              duty_r  <= '0;
              sat_r   <= 1'b0;
              fault_r <= 1'b1;
`ifdef PWM_FAULT_LATCH_EN
              state   <= FAULT;
`endif
            end else begin
              duty_r  <= duty_c;
              sat_r   <= sat_c;
              fault_r <= 1'b0;
            end
          end
        end

        RUN: begin
          if (boundary) begin
            cnt      <= '0;
            period_r <= i_period;
            if (i_period == '0) begin
              state   <= IDLE;
              duty_r  <= '0;
              dir_r   <= 1'b0;
              sat_r   <= 1'b0;
              fault_r <= 1'b0;
            end else if (!inv_c) begin
              duty_r  <= duty_c;
              dir_r   <= dir_c;
              sat_r   <= sat_c;
              fault_r <= 1'b0;
            end else begin
              // Previous duty and direction stay applied for this period.
              fault_r <= 1'b1;
`ifdef PWM_FAULT_LATCH_EN
              state   <= FAULT;
`endif
            end
          end else begin
            cnt <= cnt + cnt_nb'(1);
          end
        end

        FAULT: begin
          cnt <= '0;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pwm   = (state == RUN) && (cnt < duty_r);
  assign o_dir   = dir_r;
  assign o_sat   = sat_r;
  assign o_fault = fault_r;
  assign o_duty  = duty_r;

endmodule
